uart_rx_core: RTL and testbench
===============================

# uart_rx_core

Serial receive engine for the UART. It recovers frames from the `Rx` line using 16x oversampling derived from the system clock. It presents each received word on `Data_Out` with a one-cycle `Data_Rdy` strobe and break/parity/frame status on `Rx_Error`. Its output feeds the receive FIFO, and in BIST mode it feeds the self-test comparator.

## Interface
Parameters:
- SYSCLK_RATE, 100000000: system clock frequency in Hz.
- BAUD_RATE, 9600: line bit rate in bit/s.
- DATA_BITS, 8: data bits per frame; legal range 1..8.
- PARITY_BIT, 1: 1 means one even-parity bit is present; 0 means no parity bit.
- STOP_BITS, 2: stop bits per frame; legal range 1..2.
- Derived DIV = SYSCLK_RATE/(BAUD_RATE*16), using integer division. DIV must be at least 1; elaboration stops with `$error` otherwise.

Ports:
- Clk, input, 1: system clock. All logic runs on its rising edge.
- Rst, input, 1: asynchronous reset, active-high.
- Rx, input, 1: serial line. Idle level is high.
- Data_Out, output, DATA_BITS: last received word.
- Data_Rdy, output, 1: one-cycle strobe marking a completed frame.
- Rx_Error, output, 3: bit0 = break, bit1 = parity, bit2 = frame.
- Rx_Busy, output, 1: high while a frame is being received or a break is in progress.

## Operation
- Frame on the line, in time order:
  - start bit (0);
  - data bits, MSB first (`Data_Out[DATA_BITS-1]` is received first);
  - parity bit, if PARITY_BIT=1. Its value equals the XOR of the data bits (even parity);
  - STOP_BITS stop bits (1).
- Input synchronizer: `Rx` passes through two flops, both reset to 1. All decisions use the synchronized value `rx_s`.
- Tick generator: a counter from 0 to DIV-1 produces a one-cycle `tick` at DIV-1. The counter is cleared on start detection, so sampling phase is deterministic.
- Sample counter: 4-bit, counts ticks 0..15 within each bit.
- State machine:
  - IDLE → START on a falling edge of `rx_s` (previous value 1, current 0). The tick and sample counters clear and `Rx_Busy` rises.
  - START: at 8 ticks (mid-bit), if `rx_s`=1 it is a false start; return to IDLE with no output update. Otherwise go to DATA with the sample counter cleared.
  - DATA: sample `rx_s` every 16 ticks and shift left into the shift register. After DATA_BITS samples, go to PARITY if PARITY_BIT=1, else to STOP.
  - PARITY: sample once after 16 ticks. Parity error = sampled bit XOR (XOR of shift register).
  - STOP: sample every 16 ticks, STOP_BITS times. Frame error if any stop sample is 0.
  - After the last stop sample, the frame completes:
    - Break = every sample of the frame (start, data, parity, stops) was 0. In that case `Rx_Error` = 3'b001 (break suppresses parity and frame) and the FSM goes to BREAK_WAIT.
    - Otherwise `Rx_Error` = {frame, parity, 1'b0} and the FSM goes to IDLE.
  - BREAK_WAIT: stay until `rx_s`=1, then go to IDLE. `Rx_Busy` stays high throughout.
- Frame completion updates registers together on one edge: `Data_Out` ← shift register, `Rx_Error` ← status, `Data_Rdy` ← 1 for exactly one cycle.
- Words with errors are still delivered with `Data_Rdy`. `Data_Out` and `Rx_Error` then hold until the next completed frame.
- No frame is lost to turnaround: a start edge arriving in the second half of the final stop bit is detected normally.

## Timing
- Reset values: `Data_Out`=0, `Data_Rdy`=0, `Rx_Error`=3'b000, `Rx_Busy`=0; FSM in IDLE; both synchronizer flops at 1; all counters at 0.
- Reset asserted mid-frame aborts the frame immediately. No `Data_Rdy` is produced. After release, the block waits for a new falling edge.
- Start detection happens 3 Clk cycles after `Rx` falls (2 synchronizer flops plus 1 edge register).
- Sample k (k=0 is the start bit) is taken at tick (8+16k) after start detection. Tick n occurs n*DIV cycles after detection.
- `Data_Rdy` is high on the cycle after the final stop sample. With N = 1+DATA_BITS+PARITY_BIT+STOP_BITS, that is ((8+16(N-1))*DIV)+1 cycles after detection.
- `Rx_Busy` falls on the same edge that `Data_Rdy` rises, on a false-start return to IDLE, or on exit from BREAK_WAIT.

## Test plan
Bench parameters: SYSCLK_RATE=1600000, BAUD_RATE=10000, which gives DIV=10 and 160 cycles per bit. Other parameters are at their defaults.
- Send 8'hA5 with parity 0 and stops 11 → exactly one `Data_Rdy` pulse; `Data_Out`=8'hA5, `Rx_Error`=3'b000; `Rx_Busy` is low afterwards.
- Send 8'hAA with inverted parity (1) → `Data_Out`=8'hAA, `Rx_Error`=3'b010.
- Send 8'hAA, parity 0, stops 00, then the line high → `Data_Out`=8'hAA, `Rx_Error`=3'b100.
- Hold `Rx` low for 12 bit times (1920 cycles), then high → `Data_Out`=8'h00, `Rx_Error`=3'b001. `Rx_Busy` stays high until 3 cycles after `Rx` returns high.
- Pulse `Rx` low for 50 cycles → no `Data_Rdy`; `Rx_Busy` pulses then clears; `Data_Out` and `Rx_Error` are unchanged.
- Assert `Rst` during data bit 3 of 8'h5A → all outputs are 0 immediately. Then send a back-to-back pair 8'h3C, 8'hC3 → two `Data_Rdy` pulses, values correct, `Rx_Error`=3'b000 for both.

Source files
------------

// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x-oversampled UART receive engine.
// The frame is start bit, DATA_BITS data bits (MSB first), an optional even-parity bit and
// STOP_BITS stop bits. Each completed frame produces one Data_Rdy strobe.
// Break, parity and frame status are reported on Rx_Error.
module uart_rx_core #(
  parameter int unsigned SYSCLK_RATE = 100000000,
  parameter int unsigned BAUD_RATE   = 9600,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_BIT  = 1,
  parameter int unsigned STOP_BITS   = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] Data_Out,
  output logic                 Data_Rdy,
  output logic [2:0]           Rx_Error,
  output logic                 Rx_Busy
);

  localparam int unsigned DIV = SYSCLK_RATE / (BAUD_RATE * 16);
  localparam int unsigned TCW = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 1) begin : g_div_check
    $error("uart_rx_core: DIV = SYSCLK_RATE/(BAUD_RATE*16) must be at least 1");
  end
  if (DATA_BITS < 1 || DATA_BITS > 8) begin : g_data_check
    $error("uart_rx_core: DATA_BITS must be in 1..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
    $error("uart_rx_core: STOP_BITS must be in 1..2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreakWait
  } state_e;

  state_e               state_q, state_d;
  logic                 rx_m_q, rx_s_q, rx_prev_q;
  logic [TCW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [3:0]           samp_cnt_q, samp_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS:0]   shift_ext;
  logic                 all_zero_q, all_zero_d;
  logic                 par_err_q, par_err_d;
  logic                 frm_err_q, frm_err_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 data_rdy_q, data_rdy_d;
  logic [2:0]           rx_err_q, rx_err_d;
  logic                 tick, mid_start, bit_end, fall;
  logic                 stop_frame, stop_zero;

  assign tick      = (tick_cnt_q == TCW'(DIV - 1));
  assign mid_start = tick && (samp_cnt_q == 4'd7);
  assign bit_end   = tick && (samp_cnt_q == 4'd15);
  assign fall      = rx_prev_q & ~rx_s_q;
  assign shift_ext = {shreg_q, rx_s_q};

  // Two-flop synchronizer plus edge register; idle level is high.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rx_m_q    <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_m_q    <= Rx;
      rx_s_q    <= rx_m_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= StIdle;
      tick_cnt_q <= '0;
      samp_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      all_zero_q <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      data_out_q <= '0;
      data_rdy_q <= 1'b0;
      rx_err_q   <= 3'b000;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      all_zero_q <= all_zero_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      data_out_q <= data_out_d;
      data_rdy_q <= data_rdy_d;
      rx_err_q   <= rx_err_d;
    end
  end

  // Next-state logic: bit sampling at mid-bit and frame completion.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    samp_cnt_d = tick ? samp_cnt_q + 4'd1 : samp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    all_zero_d = all_zero_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    data_out_d = data_out_q;
    data_rdy_d = 1'b0;
    rx_err_d   = rx_err_q;
    stop_frame = frm_err_q | ~rx_s_q;
    stop_zero  = all_zero_q & ~rx_s_q;
    case (state_q)
      StIdle: begin
        if (fall) begin
          state_d    = StStart;
          tick_cnt_d = '0;
          samp_cnt_d = '0;
        end
      end
      StStart: begin
        if (mid_start) begin
          if (rx_s_q) begin
            state_d = StIdle;
          end else begin
            state_d    = StData;
            samp_cnt_d = '0;
            bit_cnt_d  = '0;
            all_zero_d = 1'b1;
            par_err_d  = 1'b0;
            frm_err_d  = 1'b0;
          end
        end
      end
      StData: begin
        if (bit_end) begin
          shreg_d    = shift_ext[DATA_BITS-1:0];
          all_zero_d = all_zero_q & ~rx_s_q;
          if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_BIT != 0) ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          par_err_d  = rx_s_q ^ (^shreg_q);
          all_zero_d = all_zero_q & ~rx_s_q;
          state_d    = StStop;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
            data_out_d = shreg_q;
            data_rdy_d = 1'b1;
            if (stop_zero) begin
              // Break overrides parity and frame status.
              rx_err_d = 3'b001;
              state_d  = StBreakWait;
            end else begin
              rx_err_d = {stop_frame, par_err_q, 1'b0};
              state_d  = StIdle;
            end
          end else begin
            frm_err_d  = stop_frame;
            all_zero_d = stop_zero;
            bit_cnt_d  = bit_cnt_q + 4'd1;
          end
        end
      end
      StBreakWait: begin
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign Data_Out = data_out_q;
  assign Data_Rdy = data_rdy_q;
  assign Rx_Error = rx_err_q;
  assign Rx_Busy  = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: table-driven and randomized frames checked against a frame-level model,
// plus break, false start, mid-frame reset and back-to-back sequences.
module tb_uart_rx_core;

  localparam int Div    = 10;
  localparam int BitCyc = 16 * Div;
  localparam int NBits  = 12;
  localparam int LatLo  = 3 + (8 + 16 * (NBits - 1)) * Div;
  localparam int LatHi  = LatLo + 1;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Rx;
  logic [7:0] Data_Out;
  logic       Data_Rdy;
  logic [2:0] Rx_Error;
  logic       Rx_Busy;

  uart_rx_core #(
    .SYSCLK_RATE(1600000),
    .BAUD_RATE  (10000)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Rx      (Rx),
    .Data_Out(Data_Out),
    .Data_Rdy(Data_Rdy),
    .Rx_Error(Rx_Error),
    .Rx_Busy (Rx_Busy)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int long_pulses = 0;
  logic prev_rdy = 1'b0;

  logic [7:0] q_data[$];
  logic [2:0] q_err[$];
  int         q_cyc[$];

  always @(posedge Clk) cyc <= cyc + 1;

  // Record every Data_Rdy strobe together with the word, status and cycle.
  always @(negedge Clk) begin
    if (Data_Rdy === 1'b1) begin
      q_data.push_back(Data_Out);
      q_err.push_back(Rx_Error);
      q_cyc.push_back(cyc);
      if (prev_rdy) long_pulses++;
    end
    prev_rdy = (Data_Rdy === 1'b1);
  end

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic [1:0] stops;
    logic [7:0] exp_data;
    logic [2:0] exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Frame-level reference: status from the spec's rules on the transmitted bits.
  function automatic logic [2:0] model_err(logic [7:0] d, logic p, logic [1:0] s);
    if (d == 8'h00 && p == 1'b0 && s == 2'b00) return 3'b001;
    return {(s != 2'b11), (p != ^d), 1'b0};
  endfunction

  // Send start, 8 data bits MSB first, parity and two stop bits; returns fall cycle.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic [1:0] s,
                            output int fc);
    logic [11:0] bits;
    bits = {1'b0, d, p, s};
    fc = cyc;
    for (int i = 11; i >= 0; i--) begin
      Rx = bits[i];
      repeat (BitCyc) @(negedge Clk);
    end
    Rx = 1'b1;
  endtask

  task automatic check_word(input string name, input int idx, input int fc,
                            input logic [7:0] ed, input logic [2:0] ee);
    if (q_data.size() > idx) begin
      chk({name, "_data"}, 32'(q_data[idx]), 32'(ed));
      chk({name, "_err"}, 32'(q_err[idx]), 32'(ee));
      chk_rng({name, "_lat"}, q_cyc[idx] - fc, LatLo, LatHi);
    end else begin
      chk({name, "_present"}, 32'(q_data.size()), 32'(idx + 1));
    end
  endtask

  vec_t vecs[5];

  initial begin
    int n0, fc, fc2;
    logic [7:0] d, last_d;
    logic p;
    logic [1:0] s;
    logic [2:0] last_e;

    vecs[0] = '{8'hA5, 1'b0, 2'b11, 8'hA5, 3'b000};
    vecs[1] = '{8'hAA, 1'b1, 2'b11, 8'hAA, 3'b010};
    vecs[2] = '{8'hAA, 1'b0, 2'b00, 8'hAA, 3'b100};
    vecs[3] = '{8'h0F, 1'b1, 2'b01, 8'h0F, 3'b110};
    vecs[4] = '{8'h01, 1'b1, 2'b10, 8'h01, 3'b100};

    Rst = 1'b1;
    Rx  = 1'b1;
    repeat (4) @(negedge Clk);
    chk("rst_data", 32'(Data_Out), 32'h0);
    chk("rst_rdy", 32'(Data_Rdy), 32'h0);
    chk("rst_err", 32'(Rx_Error), 32'h0);
    chk("rst_busy", 32'(Rx_Busy), 32'h0);
    Rst = 1'b0;
    repeat (20) @(negedge Clk);

    // Table-driven frames.
    for (int i = 0; i < 5; i++) begin
      n0 = q_data.size();
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stops, fc);
      repeat (120) @(negedge Clk);
      chk($sformatf("vec%0d_count", i), 32'(q_data.size()), 32'(n0 + 1));
      check_word($sformatf("vec%0d", i), n0, fc, vecs[i].exp_data, vecs[i].exp_err);
      chk($sformatf("vec%0d_busy", i), 32'(Rx_Busy), 32'h0);
    end

    // Break: 12 bit times low, then high.
    n0 = q_data.size();
    fc = cyc;
    Rx = 1'b0;
    repeat (12 * BitCyc) @(negedge Clk);
    chk("brk_busy_low", 32'(Rx_Busy), 32'h1);
    Rx = 1'b1;
    repeat (2) @(negedge Clk);
    chk("brk_busy_2cyc", 32'(Rx_Busy), 32'h1);
    @(negedge Clk);
    chk("brk_busy_3cyc", 32'(Rx_Busy), 32'h0);
    chk("brk_count", 32'(q_data.size()), 32'(n0 + 1));
    check_word("brk", n0, fc, 8'h00, 3'b001);
    repeat (50) @(negedge Clk);

    // Randomized frames against the model.
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      p = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      if (d == 8'h00 && p == 1'b0 && s == 2'b00) d = 8'h80;
      n0 = q_data.size();
      send_frame(d, p, s, fc);
      repeat (120) @(negedge Clk);
      chk($sformatf("rnd%0d_count", i), 32'(q_data.size()), 32'(n0 + 1));
      check_word($sformatf("rnd%0d", i), n0, fc, d, model_err(d, p, s));
      last_d = d;
      last_e = model_err(d, p, s);
    end

    // False start: 50-cycle low glitch.
    n0 = q_data.size();
    Rx = 1'b0;
    repeat (10) @(negedge Clk);
    chk("fs_busy_high", 32'(Rx_Busy), 32'h1);
    repeat (40) @(negedge Clk);
    Rx = 1'b1;
    repeat (150) @(negedge Clk);
    chk("fs_busy_clear", 32'(Rx_Busy), 32'h0);
    chk("fs_no_rdy", 32'(q_data.size()), 32'(n0));
    chk("fs_data_hold", 32'(Data_Out), 32'(last_d));
    chk("fs_err_hold", 32'(Rx_Error), 32'(last_e));

    // Reset during data bit 3 of 8'h5A (start, d7..d4 sent, half of d3).
    n0 = q_data.size();
    Rx = 1'b0;
    repeat (BitCyc) @(negedge Clk);
    for (int i = 7; i >= 4; i--) begin
      d = 8'h5A;
      Rx = d[i];
      repeat (BitCyc) @(negedge Clk);
    end
    Rx = 1'b1;
    repeat (BitCyc / 2) @(negedge Clk);
    chk("mid_busy", 32'(Rx_Busy), 32'h1);
    Rst = 1'b1;
    #1;
    chk("mid_rst_data", 32'(Data_Out), 32'h0);
    chk("mid_rst_rdy", 32'(Data_Rdy), 32'h0);
    chk("mid_rst_err", 32'(Rx_Error), 32'h0);
    chk("mid_rst_busy", 32'(Rx_Busy), 32'h0);
    repeat (5) @(negedge Clk);
    Rst = 1'b0;
    repeat (BitCyc * 4) @(negedge Clk);
    chk("mid_no_rdy", 32'(q_data.size()), 32'(n0));
    chk("mid_busy_after", 32'(Rx_Busy), 32'h0);

    // Back-to-back pair.
    n0 = q_data.size();
    send_frame(8'h3C, 1'b0, 2'b11, fc);
    send_frame(8'hC3, 1'b0, 2'b11, fc2);
    repeat (120) @(negedge Clk);
    chk("pair_count", 32'(q_data.size()), 32'(n0 + 2));
    check_word("pair0", n0, fc, 8'h3C, 3'b000);
    check_word("pair1", n0 + 1, fc2, 8'hC3, 3'b000);
    chk("pair_busy", 32'(Rx_Busy), 32'h0);

    chk("rdy_width", 32'(long_pulses), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
